// File: rtl/ssd_scan_ctrl.sv
// Signed 8-bit value to sign + 3 BCD digit converter (iterative shift-add-3) with a
// 4-digit time-multiplexed common-anode scan output for the downstream ssd_driver.
module ssd_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       ssd_scan_port_clk,
  input  logic       ssd_scan_port_rst,
  input  logic [7:0] ssd_scan_port_val,
  input  logic       ssd_scan_port_load,
  output logic       ssd_scan_port_busy,
  output logic       ssd_scan_port_done,
  output logic [3:0] ssd_scan_port_digit,
  output logic [3:0] ssd_scan_port_an
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  localparam logic [3:0] CodeBlank = 4'hA;
  localparam logic [3:0] CodePos   = 4'hE;
  localparam logic [3:0] CodeNeg   = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StCommit
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [7:0]      r_mag;
  logic            r_sign;
  logic [11:0]     r_bcd;
  logic [2:0]      r_bit_cnt;
  logic            r_done;
  logic [3:0][3:0] r_disp;
  logic [CntW-1:0] r_ref_cnt;
  logic [1:0]      r_idx;

  logic [7:0]      w_mag_in;
  logic [11:0]     w_bcd_adj;
  logic [3:0][3:0] w_disp_new;
  logic [3:0]      w_hund;
  logic [3:0]      w_tens;
  logic [3:0]      w_ones;

  // -128 negates to 8'h80, which reads correctly as unsigned 128.
  assign w_mag_in = ssd_scan_port_val[7] ? (~ssd_scan_port_val + 8'd1) : ssd_scan_port_val;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  assign w_hund = r_bcd[11:8];
  assign w_tens = r_bcd[7:4];
  assign w_ones = r_bcd[3:0];

  always_comb begin
    w_disp_new    = '0;
    w_disp_new[3] = r_sign ? CodeNeg : CodePos;
    w_disp_new[2] = (w_hund == 4'd0) ? CodeBlank : w_hund;
    w_disp_new[1] = ((w_hund == 4'd0) && (w_tens == 4'd0)) ? CodeBlank : w_tens;
    w_disp_new[0] = w_ones;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (ssd_scan_port_load) w_state_nxt = StConv;
      StConv:   if (r_bit_cnt == 3'd0) w_state_nxt = StCommit;
      StCommit: w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge ssd_scan_port_clk) begin
    if (ssd_scan_port_rst) begin
      r_state   <= StIdle;
      r_mag     <= '0;
      r_sign    <= 1'b0;
      r_bcd     <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
      r_disp    <= {CodeBlank, CodeBlank, CodeBlank, CodeBlank};
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == StCommit);
      unique case (r_state)
        StIdle: begin
          if (ssd_scan_port_load) begin
            r_mag     <= w_mag_in;
            r_sign    <= ssd_scan_port_val[7];
            r_bcd     <= '0;
            r_bit_cnt <= 3'd7;
          end
        end
        StConv: begin
          // Top BCD bit falls off the shift; hundreds never exceeds 2.
          {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
          r_bit_cnt      <= r_bit_cnt - 3'd1;
        end
        StCommit: r_disp <= w_disp_new;
        default: ;
      endcase
    end
  end

  // Scan runs free of the converter so the display never flickers during conversion.
  always_ff @(posedge ssd_scan_port_clk) begin
    if (ssd_scan_port_rst) begin
      r_ref_cnt <= '0;
      r_idx     <= 2'd0;
    end else if (r_ref_cnt == CntMax) begin
      r_ref_cnt <= '0;
      r_idx     <= r_idx + 2'd1;
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  assign ssd_scan_port_busy  = (r_state != StIdle);
  assign ssd_scan_port_done  = r_done;
  assign ssd_scan_port_digit = r_disp[r_idx];
  assign ssd_scan_port_an    = ~(4'b0001 << r_idx);

endmodule
